// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU family.
// Contents: opcode encodings, opcode field width, immediate field positions,
// sequencer FSM state type and an illegal-opcode helper.
package cpu19_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_I    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_S    = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_CALL = 5'b00110;
  localparam logic [OPC_W-1:0] OP_RET  = 5'b00111;

  // Branch offset (8-bit two's complement) and jump/call target fields
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;
  localparam int JIMM_MSB = 13;
  localparam int JIMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  function automatic logic op_is_illegal(input logic [OPC_W-1:0] op);
    return (op > OP_RET);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle for the PC sequencer.
// Groups the instruction-memory fetch handshake (imem_req/imem_addr/imem_ack/
// imem_rdata) and the downstream issue handshake (instr_valid/instr/pc_out/
// core_ready) plus the branch-compare input br_eq.
//   master : the sequencer side
//   slave  : instruction memory + datapath side
interface pc_sequencer_if #(
  parameter int PC_W    = 14,
  parameter int INSTR_W = 19
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_out;
  logic               core_ready;
  logic               br_eq;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ack, imem_rdata, core_ready, br_eq
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ack, imem_rdata, core_ready, br_eq
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: hardware return-address LIFO for the PC sequencer.
// Ports:
//   clk, rst (async, active-low)
//   push/din  : push a return address (ignored when full)
//   pop       : discard the top entry (ignored when empty)
//   top       : current top-of-stack, valid when !empty
//   count     : number of stored entries
//   full/empty: status flags
// push and pop are never asserted in the same cycle.
module ret_stack #(
  parameter int PC_W        = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [PC_W-1:0]                    din,
  output logic [PC_W-1:0]                    top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   count,
  output logic                               full,
  output logic                               empty
);

  localparam int CW = $clog2(STACK_DEPTH+1);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] mem [0:STACK_DEPTH-1];
  logic [CW-1:0]   count_reg;
  logic [PC_W-1:0] top_reg;
  logic [CW-1:0]   below_idx;

  // Index of the entry that becomes the new top after a pop
  assign below_idx = count_reg - CW'(2);

  assign full  = (count_reg == CW'(STACK_DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign top   = top_reg;

  // Storage array: written on push, no reset needed
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[count_reg[AW-1:0]] <= din;
  end

  // The top entry is kept in a register so the sequencer sees it without a
  // read delay; the array itself is only read at the clock edge of a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      top_reg   <= '0;
    end else if (push && !full) begin
      count_reg <= count_reg + CW'(1);
      top_reg   <= din;
    end else if (pop && !empty) begin
      count_reg <= count_reg - CW'(1);
      top_reg   <= (count_reg >= CW'(2)) ? mem[below_idx[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle program-counter sequencer for the 19-bit CPU.
// Fetches over imem_req/imem_ack, issues over instr_valid/core_ready and
// resolves BEQ/BNE/JMP/CALL/RET internally with a return-address stack.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   bus         pc_sequencer_if.master (fetch + issue handshakes, br_eq)
//   illegal_op  one-cycle pulse after accepting an opcode above RET
//   trap        sticky return-stack overflow/underflow
//   stack_count entries currently in the return stack
module pc_sequencer
  import cpu19_pkg::*;
#(
  parameter int INSTR_W     = 19,
  parameter int PC_W        = 14,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  pc_sequencer_if.master                    bus,
  output logic                              illegal_op,
  output logic                              trap,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_count
);

  state_t             state_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               imem_req_reg;
  logic [PC_W-1:0]    imem_addr_reg;
  logic               instr_valid_reg;
  logic [PC_W-1:0]    pc_out_reg;
  logic               illegal_reg;
  logic               trap_reg;

  logic [OPC_W-1:0]   opcode;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    br_off;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    stk_top;
  logic               stk_full;
  logic               stk_empty;
  logic               accept;
  logic               stk_push;
  logic               stk_pop;
  logic               stack_fault;

  assign opcode      = instr_reg[INSTR_W-1 -: OPC_W];
  assign pc_plus1    = pc_reg + PC_W'(1);
  // Sign-extend the 8-bit offset to PC width; sums then wrap naturally
  assign br_off      = PC_W'($signed(instr_reg[IMM8_MSB:IMM8_LSB]));
  assign jump_target = PC_W'(instr_reg[JIMM_MSB:JIMM_LSB]);
  assign accept      = (state_reg == ST_ISSUE) && bus.core_ready;

  always_comb begin
    pc_next     = pc_plus1;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stack_fault = 1'b0;
    case (opcode)
      OP_BEQ:  pc_next = bus.br_eq  ? pc_plus1 + br_off : pc_plus1;
      OP_BNE:  pc_next = !bus.br_eq ? pc_plus1 + br_off : pc_plus1;
      OP_JMP:  pc_next = jump_target;
      OP_CALL: begin
        pc_next     = jump_target;
        stk_push    = accept && !stk_full;
        stack_fault = accept && stk_full;
      end
      OP_RET: begin
        pc_next     = stk_top;
        stk_pop     = accept && !stk_empty;
        stack_fault = accept && stk_empty;
      end
      default: pc_next = pc_plus1;
    endcase
  end

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_plus1),
    .top   (stk_top),
    .count (stack_count),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= PC_W'(RESET_PC);
      instr_reg       <= '0;
      imem_req_reg    <= 1'b0;
      imem_addr_reg   <= '0;
      instr_valid_reg <= 1'b0;
      pc_out_reg      <= '0;
      illegal_reg     <= 1'b0;
      trap_reg        <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          state_reg     <= ST_FETCH;
          imem_req_reg  <= 1'b1;
          imem_addr_reg <= pc_reg;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr_reg       <= bus.imem_rdata;
            imem_req_reg    <= 1'b0;
            imem_addr_reg   <= '0;
            instr_valid_reg <= 1'b1;
            pc_out_reg      <= pc_reg;
            state_reg       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.core_ready) begin
            instr_valid_reg <= 1'b0;
            pc_out_reg      <= '0;
            if (stack_fault) begin
              // PC and stack stay as they were; only reset leaves TRAP
              trap_reg  <= 1'b1;
              state_reg <= ST_TRAP;
            end else begin
              pc_reg        <= pc_next;
              imem_req_reg  <= 1'b1;
              imem_addr_reg <= pc_next;
              illegal_reg   <= op_is_illegal(opcode);
              state_reg     <= ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = imem_addr_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.pc_out      = pc_out_reg;
  assign illegal_op      = illegal_reg;
  assign trap            = trap_reg;

endmodule
